// File: rtl/ps2_led_ctrl_if.sv
// Byte-level link between the LED sequencer, the PS/2 receiver/transmitter pair
// and the keyboard decoder. The master modport is the sequencer side.
interface ps2_led_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       dec_ena;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_busy,
        input  tx_done,
        input  tx_err,
        output dec_ena,
        output tx_req,
        output tx_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_busy,
        output tx_done,
        output tx_err,
        input  dec_ena,
        input  tx_req,
        input  tx_data
    );
endinterface

// File: rtl/ps2_led_ctrl.sv
// PS/2 keyboard LED sequencer. Sends 0xED + LED byte whenever the lock state
// differs from the last committed value, swallows the keyboard's 0xFA/0xFE
// replies, and retries on resend, transmit error or reply timeout.
// Optional build macro PS2_LED_RETRY_EN: when defined each byte is retried up to
// MAX_RETRY times; when undefined any failure abandons the transaction at once.
module ps2_led_ctrl #(
    parameter int unsigned TIMEOUT   = 480000,
    parameter int unsigned TO_W      = 20,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  caps_lock,
    input  logic                  num_lock,
    input  logic                  scroll_lock,
    ps2_led_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  err
);

    localparam logic [7:0] CMD_LED = 8'hED;
    localparam logic [7:0] RSP_ACK = 8'hFA;
    localparam logic [7:0] RSP_RES = 8'hFE;

    // Elaboration-time parameter sanity checks
    if ((64'd1 << TO_W) <= 64'(TIMEOUT)) begin : g_bad_to_w
        $error("TO_W too narrow to hold TIMEOUT");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be non-zero");
    end
    if (MAX_RETRY > 255) begin : g_bad_retry
        $error("MAX_RETRY must fit in 8 bits");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSendCmd,
        StWaitAck1,
        StSendLed,
        StWaitAck2
    } state_t;

    state_t            state;
    logic [2:0]        leds;
    logic [2:0]        sent;
    logic [2:0]        snap;
    logic [TO_W-1:0]   timer;
    logic              req_pend;
    logic              consume;
    logic              step_ok;
    logic              step_fail;
    logic              can_retry;

`ifdef PS2_LED_RETRY_EN
    logic [7:0]        retry;
    assign can_retry = (retry < 8'(MAX_RETRY));
`else
    assign can_retry = 1'b0;
`endif

    assign leds = {caps_lock, num_lock, scroll_lock};

    // Request is gated live by tx_busy so it can never be raised while the
    // transmitter is busy, even if busy rises without warning.
    assign bus.tx_req = req_pend & ~bus.tx_busy;

    // Keyboard replies are swallowed only while a reply is expected
    always_comb begin
        consume = 1'b0;
        if ((state == StWaitAck1) || (state == StWaitAck2)) begin
            consume = (bus.rx_data == RSP_ACK) || (bus.rx_data == RSP_RES);
        end
    end

    assign bus.dec_ena = bus.rx_valid & ~consume;

    // Per-state success/failure decode; tx_err beats tx_done, a reply beats timeout
    always_comb begin
        step_ok   = 1'b0;
        step_fail = 1'b0;
        unique case (state)
            StSendCmd, StSendLed: begin
                if (!req_pend) begin
                    if (bus.tx_err) begin
                        step_fail = 1'b1;
                    end else if (bus.tx_done) begin
                        step_ok = 1'b1;
                    end
                end
            end
            StWaitAck1, StWaitAck2: begin
                if (bus.rx_valid && (bus.rx_data == RSP_ACK)) begin
                    step_ok = 1'b1;
                end else if (bus.rx_valid && (bus.rx_data == RSP_RES)) begin
                    step_fail = 1'b1;
                end else if (timer == TO_W'(TIMEOUT - 1)) begin
                    step_fail = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            bus.tx_data <= 8'h00;
            busy        <= 1'b0;
            err         <= 1'b0;
            timer       <= '0;
            sent        <= 3'b000;
            snap        <= 3'b000;
            req_pend    <= 1'b0;
`ifdef PS2_LED_RETRY_EN
            retry       <= 8'd0;
`endif
        end else begin
            err <= 1'b0;
            if (bus.tx_req) begin
                req_pend <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (leds != sent) begin
                        snap        <= leds;
                        state       <= StSendCmd;
                        busy        <= 1'b1;
                        bus.tx_data <= CMD_LED;
                        req_pend    <= 1'b1;
`ifdef PS2_LED_RETRY_EN
                        retry       <= 8'd0;
`endif
                    end
                end
                StSendCmd, StSendLed: begin
                    if (step_ok) begin
                        state <= (state == StSendCmd) ? StWaitAck1 : StWaitAck2;
                        timer <= '0;
                    end
                end
                StWaitAck1: begin
                    timer <= timer + TO_W'(1);
                    if (step_ok) begin
                        state       <= StSendLed;
                        bus.tx_data <= {5'b00000, snap};
                        req_pend    <= 1'b1;
`ifdef PS2_LED_RETRY_EN
                        retry       <= 8'd0;
`endif
                    end
                end
                StWaitAck2: begin
                    timer <= timer + TO_W'(1);
                    if (step_ok) begin
                        sent  <= snap;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Fail path: resend the same byte, or give up and commit snap so a
            // dead keyboard cannot cause an endless stream of attempts.
            if (step_fail) begin
                if (can_retry) begin
`ifdef PS2_LED_RETRY_EN
                    retry <= retry + 8'd1;
`endif
                    req_pend <= 1'b1;
                    state    <= ((state == StSendCmd) || (state == StWaitAck1)) ?
                                StSendCmd : StSendLed;
                end else begin
                    err   <= 1'b1;
                    sent  <= snap;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Self-checking bench for ps2_led_ctrl: a transmitter/keyboard responder driven
// by random reply outcomes, checked against a per-byte attempt model.
module tb_ps2_led_ctrl;

    localparam int unsigned TIMEOUT   = 40;
    localparam int unsigned TO_W      = 6;
    localparam int unsigned MAX_RETRY = 3;
`ifdef PS2_LED_RETRY_EN
    localparam int unsigned RETRY_LIM = MAX_RETRY;
`else
    localparam int unsigned RETRY_LIM = 0;
`endif

    localparam int OC_OK     = 0;
    localparam int OC_RESEND = 1;
    localparam int OC_TXERR  = 2;
    localparam int OC_SILENT = 3;

    localparam int M_RAND    = 0;
    localparam int M_ACK     = 1;
    localparam int M_FE1     = 2;
    localparam int M_SILENT2 = 3;
    localparam int M_TOGGLE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic caps_lock = 1'b1;
    logic num_lock = 1'b0;
    logic scroll_lock = 1'b0;
    logic busy;
    logic err;

    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    int bad_req = 0;
    int exp_req_cnt = 0;

    ps2_led_ctrl_if bus ();

    ps2_led_ctrl #(
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .caps_lock  (caps_lock),
        .num_lock   (num_lock),
        .scroll_lock(scroll_lock),
        .bus        (bus),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Count transmit requests and any request raised while the transmitter is busy
    always @(posedge clk) begin
        if (!rst && bus.tx_req === 1'b1) begin
            req_cnt <= req_cnt + 1;
            if (bus.tx_busy) bad_req <= bad_req + 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_leds(input logic [2:0] v);
        {caps_lock, num_lock, scroll_lock} = v;
    endtask

    task automatic wait_req(output bit got, output logic [7:0] d);
        #1;
        got = 1'b0;
        d = 8'h00;
        for (int i = 0; i < int'(TIMEOUT) + 40; i++) begin
            if (bus.tx_req === 1'b1) begin
                got = 1'b1;
                d = bus.tx_data;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 40; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Transmitter: go busy, then finish with done or error (error may carry done)
    task automatic send_tx(input bit fail);
        tick();
        bus.tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        bus.tx_busy = 1'b0;
        if (fail) begin
            bus.tx_err  = 1'b1;
            bus.tx_done = 1'($urandom_range(0, 1));
        end else begin
            bus.tx_done = 1'b1;
        end
        tick();
        bus.tx_done = 1'b0;
        bus.tx_err  = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic exp_ena, input string tag);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        #1;
        check(tag, bus.dec_ena, exp_ena);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    function automatic int pick(input int mode, input int phase, input int attempt);
        int r;
        case (mode)
            M_FE1:     return (phase == 0 && attempt == 0) ? OC_RESEND : OC_OK;
            M_SILENT2: return (phase == 0) ? OC_OK : OC_SILENT;
            M_RAND: begin
                r = int'($urandom_range(0, 9));
                if (r < 6) return OC_OK;
                if (r == 6) return OC_RESEND;
                if (r == 7) return OC_TXERR;
                return OC_SILENT;
            end
            default:   return OC_OK;
        endcase
    endfunction

    // One LED transaction: each attempt's byte is predicted from the phase, the
    // outcome is chosen, and the retry budget decides complete/retry/abandon.
    task automatic run_txn(input logic [2:0] snap, input int mode, input logic [2:0] mid_leds);
        int phase = 0;
        int retries = 0;
        int attempt = 0;
        bit fin = 1'b0;
        bit abandon = 1'b0;
        bit got;
        bit ok;
        int oc;
        logic [7:0] d;
        logic [7:0] exp_b;
        while (!fin) begin
            wait_req(got, d);
            check("tx_req issued", 32'(got), 32'd1);
            if (!got) return;
            exp_req_cnt++;
            exp_b = (phase == 0) ? 8'hED : {5'b00000, snap};
            check("tx_data", 32'(d), 32'(exp_b));
            check("busy in txn", 32'(busy), 32'd1);
            oc = pick(mode, phase, attempt);
            attempt++;
            send_tx(oc == OC_TXERR);
            if (oc == OC_OK || oc == OC_RESEND) begin
                repeat ($urandom_range(0, 3)) tick();
                if (mode == M_TOGGLE && phase == 1) set_leds(mid_leds);
                rx_byte((oc == OC_OK) ? 8'hFA : 8'hFE, 1'b0, "reply consumed");
            end else if (oc == OC_SILENT) begin
                repeat (3) tick();
                rx_byte(8'($urandom_range(0, 8'hF9)), 1'b1, "stray byte passes");
            end
            if (oc == OC_OK) begin
                if (phase == 0) begin
                    phase = 1;
                    retries = 0;
                end else begin
                    fin = 1'b1;
                end
            end else if (retries < int'(RETRY_LIM)) begin
                retries++;
            end else begin
                fin = 1'b1;
                abandon = 1'b1;
            end
        end
        wait_idle(ok);
        check("busy falls", 32'(ok), 32'd1);
        check("err at end", 32'(err), 32'(abandon));
        tick();
        check("err one cycle", 32'(err), 32'd0);
        check("request count", 32'(req_cnt), 32'(exp_req_cnt));
    endtask

    initial begin
        bit got;
        logic [7:0] d;
        logic [2:0] cur;
        logic [2:0] nv;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;
        bus.tx_err   = 1'b0;

        repeat (3) tick();
        check("reset tx_req", 32'(bus.tx_req), 32'd0);
        check("reset tx_data", 32'(bus.tx_data), 32'h00);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset dec_ena", 32'(bus.dec_ena), 32'd0);
        rst = 1'b0;

        // Post-reset transaction driven by caps_lock=1 from the decoder
        run_txn(3'b100, M_ACK, 3'b000);

        // Idle pass-through, including an unsolicited ACK byte
        repeat (5) tick();
        rx_byte(8'h1C, 1'b1, "idle scan code");
        rx_byte(8'hFA, 1'b1, "idle FA passes");
        repeat (10) tick();
        check("no idle request", 32'(req_cnt), 32'(exp_req_cnt));

        set_leds(3'b110);
        run_txn(3'b110, M_FE1, 3'b000);

        set_leds(3'b101);
        run_txn(3'b101, M_SILENT2, 3'b000);
        repeat (20) tick();
        check("no request after give-up", 32'(req_cnt), 32'(exp_req_cnt));

        // Lock change while awaiting the LED ACK starts a follow-up transaction
        set_leds(3'b100);
        run_txn(3'b100, M_TOGGLE, 3'b000);
        run_txn(3'b000, M_ACK, 3'b000);

        // Transmitter busy holds off the request
        bus.tx_busy = 1'b1;
        set_leds(3'b011);
        repeat (50) tick();
        check("held off by tx_busy", 32'(req_cnt), 32'(exp_req_cnt));
        check("busy while held", 32'(busy), 32'd1);
        bus.tx_busy = 1'b0;
        run_txn(3'b011, M_ACK, 3'b000);

        // Reset during WAIT_ACK1
        set_leds(3'b001);
        wait_req(got, d);
        check("pre-reset req", 32'(got), 32'd1);
        exp_req_cnt++;
        send_tx(1'b0);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid rst tx_req", 32'(bus.tx_req), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst tx_data", 32'(bus.tx_data), 32'h00);
        check("mid rst err", 32'(err), 32'd0);
        tick();
        check("rst held err", 32'(err), 32'd0);
        rst = 1'b0;
        run_txn(3'b001, M_ACK, 3'b000);

        // Random outcomes
        cur = 3'b001;
        for (int n = 0; n < 12; n++) begin
            nv = 3'($urandom_range(0, 7));
            while (nv == cur) nv = 3'($urandom_range(0, 7));
            set_leds(nv);
            run_txn(nv, M_RAND, 3'b000);
            cur = nv;
        end

        repeat (20) tick();
        check("final request count", 32'(req_cnt), 32'(exp_req_cnt));
        check("req while busy", 32'(bad_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_led_ctrl.md
Name: ps2_led_ctrl

Overview:
Host-side sequencer that keeps the PS/2 keyboard LEDs in step with the lock state held by the keyboard decoder. It watches the caps/num/scroll lock inputs and runs the two-byte 0xED + LED-byte command through the PS/2 transmitter. It consumes the keyboard's 0xFA (ACK) and 0xFE (resend) replies so they never reach the decoder, and retries on resend, transmit error or timeout. It sits between the PS/2 receiver/transmitter pair and the keyboard decoder.

Parameters:
TIMEOUT, 480000, cycles to wait for a reply after tx_done (20 ms at 24 MHz)
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT
MAX_RETRY, 3, retries per byte before the transaction is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
caps_lock  in  1  caps lock state from the decoder
num_lock  in  1  num lock state
scroll_lock  in  1  scroll lock state
rx_valid  in  1  one-cycle strobe: received byte available
rx_data  in  8  received byte
dec_ena  out  1  strobe to the decoder's ena; decoder code input is rx_data directly
tx_req  out  1  one-cycle request to the transmitter
tx_data  out  8  byte to transmit, stable from tx_req until tx_done or tx_err
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle strobe: byte sent and device line-ACKed
tx_err  in  1  one-cycle strobe: transmit failed
busy  out  1  transaction in progress
err  out  1  one-cycle pulse when a transaction is abandoned

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- LED vector leds = {5'b0, caps_lock, num_lock, scroll_lock}.
- Shadow register sent[2:0] holds the last committed LED value; it resets to 3'b000.
- Reset values: state=IDLE, tx_req=0, tx_data=8'h00, busy=0, err=0, retry=0, timer=0, sent=0.
- dec_ena = rx_valid & ~consume, combinational. consume=1 only in WAIT_ACK1/WAIT_ACK2 when rx_data is 8'hFA or 8'hFE. All other bytes pass through in every state.
- States:
  - IDLE: if leds[2:0] != sent, latch snap=leds[2:0] and go to SEND_CMD with busy=1 and retry=0.
  - SEND_CMD: drive tx_data=8'hED. Pulse tx_req for one cycle on the first cycle in which tx_busy=0. On tx_done go to WAIT_ACK1 with timer=0. On tx_err take the fail path.
  - WAIT_ACK1: timer increments each cycle.
    - rx 8'hFA: go to SEND_LED with retry=0.
    - rx 8'hFE: fail path.
    - timer==TIMEOUT-1: fail path.
  - SEND_LED: drive tx_data={5'b0,snap}, same request rule as SEND_CMD. On tx_done go to WAIT_ACK2. On tx_err take the fail path.
  - WAIT_ACK2: as WAIT_ACK1, except 8'hFA commits sent<=snap, drops busy and returns to IDLE.
- Fail path: if retry<MAX_RETRY, retry++ and re-enter the current SEND state (same byte). Otherwise pulse err for one cycle, set sent<=snap to prevent livelock, drop busy and go to IDLE.
- tx_req is never asserted while tx_busy=1 and never more than once per SEND entry.
- Lock changes during a transaction do not alter snap. The mismatch is picked up on the next IDLE cycle and triggers a new transaction.
- rx_valid and timeout in the same cycle: the received byte wins.
- tx_done and tx_err in the same cycle: tx_err wins.
- Reset mid-transaction aborts immediately. tx_req drops; no err pulse.
- Because sent resets to 0 and the decoder resets caps_lock=1, one LED transaction runs automatically after reset.

Optional Feature:
PS2_LED_RETRY_EN
- Defined: retry behaviour as above, up to MAX_RETRY per byte.
- Undefined: any fail event (FE, tx_err, timeout) takes the abandon branch at once. The retry counter is not built; MAX_RETRY is ignored.

Test Plan:
- Post-reset, caps=1, num=0, scroll=0 -> tx_req with tx_data=8'hED. Reply FA -> tx_req with 8'h04. Reply FA -> busy falls, err=0, dec_ena never pulses for either FA.
- Idle, rx_valid with 8'h1C -> dec_ena pulses the same cycle. Idle, rx 8'hFA -> dec_ena pulses (not consumed).
- WAIT_ACK1, rx 8'hFE -> 8'hED retransmitted. Then FA, FA -> completes with retry logged as 1.
- No reply after the LED byte -> after TIMEOUT cycles the LED byte is resent. Four silent timeouts with MAX_RETRY=3 -> single err pulse, busy=0, sent=snap, no further tx_req.
- caps toggles 1->0 during WAIT_ACK2 (snap=3'b100) -> after FA, a new transaction sends 8'hED then 8'h00.
- tx_busy held high for 50 cycles in SEND_CMD -> tx_req stays low, then asserts exactly once after tx_busy falls. rst asserted mid-WAIT_ACK1 -> outputs at reset values next edge.
